// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// One transaction in flight; the access executes LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 1024,
    parameter logic [WIDTH-1:0] BASE    = 32'h8000_0000,
    parameter int unsigned      LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic               req_wen,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_wmask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic               busy
);
    localparam int unsigned      NB       = WIDTH / 8;
    localparam int unsigned      OB       = $clog2(NB);
    localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);
    localparam logic [3:0]       CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [NB-1:0]    wmask_q;
    logic             wen_q, err_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] idx_s, rd_word_s;
    logic [AW-1:0]    widx_s;
    logic             err_s, access_s, hs_s;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    mask
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and access-edge qualification for the held request
    always_comb begin
        idx_s     = (addr_q - BASE) >> OB;
        widx_s    = idx_s[AW-1:0];
        err_s     = (addr_q < BASE) || (idx_s >= DEPTH_W) || (addr_q[OB-1:0] != {OB{1'b0}});
        access_s  = (state_q == S_BUSY) && (cnt_q == 4'd0);
        hs_s      = req_valid && req_ready;
        rd_word_s = mem_q[widx_s];
    end

    // Storage write on the access edge; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (access_s && wen_q && !err_s && !rst) begin
            mem_q[widx_s] <= merge_bytes(rd_word_s, wdata_q, wmask_q);
        end
    end

    // FSM state and latency counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM output decode
    always_comb begin
        req_ready = (state_q == S_IDLE) && !rst;
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Request capture at handshake and response capture at the access edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= {WIDTH{1'b0}};
            wdata_q <= {WIDTH{1'b0}};
            wmask_q <= {NB{1'b0}};
            wen_q   <= 1'b0;
            rdata_q <= {WIDTH{1'b0}};
            err_q   <= 1'b0;
        end else begin
            if (hs_s) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
                wen_q   <= req_wen;
            end
            // Errors and writes both answer with zero data
            if (access_s) begin
                err_q   <= err_s;
                rdata_q <= (err_s || wen_q) ? {WIDTH{1'b0}} : rd_word_s;
            end
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WIDTH, default 32: data and address width in bits.
REQ-002 Parameter DEPTH, default 1024: number of WIDTH-bit words in storage.
REQ-003 Parameter BASE, default 32'h8000_0000: byte address of word 0.
REQ-004 Parameter LATENCY, default 2, legal range 1..15: cycles from request handshake to response valid.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have the following request, response and status ports:
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  WIDTH  byte address.
- req_wen  input  1  1 = write, 0 = read.
- req_wdata  input  WIDTH  write data.
- req_wmask  input  WIDTH/8  byte-lane write enables.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  WIDTH  read data.
- rsp_err  output  1  access error.
- busy  output  1  the state is not IDLE.

Function
REQ-007 The block SHALL use a three-state FSM: IDLE, BUSY and RESP.
REQ-008 req_ready SHALL equal (state==IDLE) && !rst, and no request SHALL be accepted in BUSY or RESP.
REQ-009 A request handshake (req_valid && req_ready at a rising edge) SHALL register addr, wen, wdata and wmask, load a down-counter with LATENCY-1, and move the FSM to BUSY.
REQ-010 In BUSY the counter SHALL decrement each cycle; at the edge where it equals 0 the access SHALL execute and the FSM SHALL move to RESP.
REQ-011 rsp_valid SHALL be asserted exactly LATENCY cycles after the handshake cycle; with LATENCY=1 it is asserted the cycle after the handshake.
REQ-012 rsp_valid, rsp_rdata and rsp_err SHALL be held stable in RESP until rsp_ready is high at a rising edge, after which the FSM SHALL return to IDLE.
REQ-013 Word index SHALL be (addr-BASE)>>log2(WIDTH/8).
REQ-014 An error SHALL be flagged when addr < BASE, when the word index is >= DEPTH, or when the low log2(WIDTH/8) address bits are nonzero.
REQ-015 On error: no storage update, rsp_err=1, rsp_rdata=0.
REQ-016 Read without error: rsp_rdata SHALL be the full stored word and rsp_err=0; wmask is ignored for reads.
REQ-017 Write without error: only bytes with wmask[i]=1 SHALL be updated, rsp_rdata=0 and rsp_err=0.
REQ-018 A write with wmask=0 SHALL complete normally with no storage change.
REQ-019 A read that follows a write to the same address SHALL return the written data, since the write executes before RESP is entered.
REQ-020 rsp_ready high while the FSM is outside RESP SHALL be ignored.
REQ-021 Request inputs SHALL be ignored outside IDLE, including while rsp_ready is held high.
REQ-022 The counter width SHALL be 4 bits, and its value SHALL not matter outside BUSY.

Reset
REQ-023 While rst is high the FSM SHALL be in IDLE, with req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and counter=0.
REQ-024 Reset asserted in BUSY or RESP SHALL abandon the transaction.
- If reset is asserted before the access edge, no storage write shall occur.
- No response SHALL be issued after reset.
REQ-025 Storage contents SHALL NOT be reset and are undefined until written.
REQ-026 req_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-027 Write addr 0x8000_0010, wdata 0xDEADBEEF, wmask 4'hF, LATENCY=2 -> rsp_valid rises 2 cycles after the handshake, with rsp_err=0 and rsp_rdata=0.
REQ-028 Read 0x8000_0010 after REQ-027, then write wdata 0x00000055 with wmask 4'b0001 and read again -> first read 0xDEADBEEF, second read 0xDEADBE55.
REQ-029 Read 0x8000_0012 (misaligned) and read 0x7FFF_FFFC (below BASE) -> rsp_err=1 and rsp_rdata=0 for both; a following read of 0x8000_0010 is unchanged.
REQ-030 Hold rsp_ready=0 for 5 cycles during a read response -> rsp_valid and rsp_rdata are constant and req_ready=0 throughout; rsp_ready=1 gives req_ready=1 the next cycle.
REQ-031 Assert rst in the BUSY cycle of a write to 0x8000_0020 (old value 0x11111111) -> no response; a read after reset returns 0x11111111.
REQ-032 Back-to-back reads with rsp_ready tied to 1 and LATENCY=1 -> handshakes every 3 cycles, with busy high between them.
